// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the instruction ROM, and buffers
// {pc, inst} pairs in a small FIFO presented to decode over valid/ready.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             head_q, head_d, new_entry;
  logic [31:0]        pc_q, pc_d;
  logic               ce_q, ce_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  // The two low target bits are discarded to keep the PC word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target_i[1:0];

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = head_q.pc;
  assign id_inst_o  = head_q.inst;
  assign new_entry  = '{pc: pc_q, inst: rom_inst_i};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ce_d     = 1'b1;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    pop      = id_valid_o & id_ready_i & ~branch_i;
    push     = ce_q & ~branch_i & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

    if (branch_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = {branch_target_i[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Next head is the entry being written when the read pointer lands on it.
      if (count_d != '0)
        head_d = (push && rd_ptr_d == wr_ptr_q) ? new_entry : mem_q[rd_ptr_d];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q     <= 1'b0;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      ce_q     <= ce_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: buffer storage is not reset; the count decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= new_entry;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed stimulus queues expected {pc, inst}
// pairs; a negedge monitor pops and compares on each accepted handshake.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, branch, ready;
  logic [31:0] target;
  logic        ce, valid;
  logic [31:0] addr, inst, id_pc, id_inst;

  logic        rst_w, ready_w;
  logic        ce_w, valid_w;
  logic [31:0] addr_w, inst_w, id_pc_w, id_inst_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // ROM holds mem[i] = i, i.e. word index of the byte address.
  assign inst   = addr >> 2;
  assign inst_w = addr_w >> 2;

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_ce_o(ce), .rom_addr_o(addr), .rom_inst_i(inst),
    .branch_i(branch), .branch_target_i(target), .id_valid_o(valid),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .id_ready_i(ready));

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst_w), .rom_ce_o(ce_w), .rom_addr_o(addr_w), .rom_inst_i(inst_w),
    .branch_i(1'b0), .branch_target_i(32'h0), .id_valid_o(valid_w),
    .id_pc_o(id_pc_w), .id_inst_o(id_inst_w), .id_ready_i(ready_w));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && !branch && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h, scoreboard empty", id_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", id_pc, e);
        check("pop_inst", id_inst, e >> 2);
      end
    end
  end

  initial begin
    rst = 1'b1; branch = 1'b0; ready = 1'b0; target = '0;
    rst_w = 1'b1; ready_w = 1'b1;

    // 1: reset state and first-fetch latency
    tick(3);
    check("rst_ce", {31'b0, ce}, 0);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_addr", addr, 0);
    rst = 1'b0;
    tick();                                   // E0
    check("e0_ce", {31'b0, ce}, 1);
    check("e0_valid", {31'b0, valid}, 0);
    tick();                                   // E1: first push
    check("e1_valid", {31'b0, valid}, 1);
    check("e1_id_pc", id_pc, 0);
    check("e1_addr", addr, 4);

    // 2: continuous ready, one instruction per cycle
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    exp_q.push_back(32'd8); exp_q.push_back(32'd12);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", {31'b0, valid}, 1);
      tick();
    end
    ready = 1'b0;
    check("stream_empty_sb", exp_q.size(), 0);

    // 3: backpressure fills the buffer and stalls the PC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    check("stall_mid_pc", id_pc, 0);
    tick(4);
    check("stall_valid", {31'b0, valid}, 1);
    check("stall_addr", addr, 32'd8);
    check("stall_id_pc", id_pc, 0);
    check("stall_id_inst", id_inst, 0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    ready = 1'b1;
    tick(3);
    ready = 1'b0;
    check("release_sb", exp_q.size(), 0);
    check("release_addr", addr, 32'd20);

    // 4: branch on a full buffer flushes it and fetches the aligned target
    branch = 1'b1; target = 32'h0000_0103;
    tick();
    branch = 1'b0; target = '0;
    check("br_valid", {31'b0, valid}, 0);
    check("br_addr", addr, 32'h100);
    tick();
    check("br_valid2", {31'b0, valid}, 1);
    check("br_id_pc", id_pc, 32'h100);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    check("br_sb", exp_q.size(), 0);

    // 6: reset dominates a simultaneous branch with entries buffered
    check("pre_rst_valid", {31'b0, valid}, 1);
    rst = 1'b1; branch = 1'b1; target = 32'h0000_0500;
    tick();
    rst = 1'b0; branch = 1'b0; target = '0;
    check("rst_br_valid", {31'b0, valid}, 0);
    check("rst_br_ce", {31'b0, ce}, 0);
    check("rst_br_addr", addr, 0);

    // back-to-back branches: the last target wins
    tick(2);
    branch = 1'b1; target = 32'h200;
    tick();
    target = 32'h300;
    tick();
    branch = 1'b0; target = '0;
    check("b2b_valid", {31'b0, valid}, 0);
    check("b2b_addr", addr, 32'h300);
    tick();
    check("b2b_id_pc", id_pc, 32'h300);
    exp_q.push_back(32'h300);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("b2b_sb", exp_q.size(), 0);

    // 5: PC wraps past the top of the address space
    rst_w = 1'b0;
    tick(2);
    check("wrap_pc0", id_pc_w, 32'hFFFF_FFF8);
    check("wrap_inst0", id_inst_w, 32'h3FFF_FFFE);
    tick();
    check("wrap_pc1", id_pc_w, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2", id_pc_w, 32'h0000_0000);
    check("wrap_inst2", id_inst_w, 32'h0000_0000);
    check("wrap_valid", {31'b0, valid_w}, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
